// File: rtl/register_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module : register_writeback_pkg
// Brief  : Shared types and constants for the register-file writeback stage:
//          write-request record, arbiter state encoding, x0 index.
// Rev    : 1.0  initial release
// ============================================================================
package register_writeback_pkg;

  localparam int c_DEF_DATA_WIDTH = 32;
  localparam int c_DEF_ADDR_WIDTH = 5;

  // Register index that is hard-wired to zero and must never be written.
  localparam int c_X0_ADDR = 0;

  // Write request at the default widths (address + data).
  typedef struct packed {
    logic [c_DEF_ADDR_WIDTH-1:0] addr;
    logic [c_DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

  // IDLE: hold buffer empty; HOLD: hold buffer carries a deferred ALU result.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/register_writeback_hold.sv
`default_nettype none
// ============================================================================
// Module : writeback_hold
// Brief  : One-entry buffer for a write request (address + data) with a
//          load enable and synchronous active-high reset. Plain register
//          outputs.
// Rev    : 1.0  initial release
// ============================================================================
module writeback_hold #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Load,
  input  logic [ADDR_WIDTH-1:0] i_Addr,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic [ADDR_WIDTH-1:0] o_Addr,
  output logic [DATA_WIDTH-1:0] o_Data
);

  logic [ADDR_WIDTH-1:0] r_Addr;
  logic [DATA_WIDTH-1:0] r_Data;

  // Capture the request on load; reset empties the entry.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Addr <= '0;
      r_Data <= '0;
    end else if (i_Load) begin
      r_Addr <= i_Addr;
      r_Data <= i_Data;
    end
  end

  assign o_Addr = r_Addr;
  assign o_Data = r_Data;

endmodule
`default_nettype wire

// File: rtl/register_writeback.sv
`default_nettype none
// ============================================================================
// Module : register_writeback
// Brief  : Arbitrates ALU and load results onto the single register-file
//          write port. Load wins a collision; the ALU result is parked in a
//          one-entry hold buffer and written on the following cycle. Writes
//          to x0 complete the handshake but never assert the write enable.
// Config : REGISTER_WRITEBACK_BYPASS_EN adds o_FwdValid/o_FwdAddr/o_FwdData,
//          a combinational view of the write being registered this cycle.
// Rev    : 1.0  initial release
// ============================================================================
module register_writeback
  import register_writeback_pkg::*;
#(
  parameter int                    DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = c_DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_AluValid,
  input  logic [ADDR_WIDTH-1:0] i_AluAddr,
  input  logic [DATA_WIDTH-1:0] i_AluData,
  output logic                  o_AluReady,
  input  logic                  i_MemValid,
  input  logic [ADDR_WIDTH-1:0] i_MemAddr,
  input  logic [DATA_WIDTH-1:0] i_MemData,
  output logic                  o_MemReady,
`ifdef REGISTER_WRITEBACK_BYPASS_EN
  output logic                  o_FwdValid,
  output logic [ADDR_WIDTH-1:0] o_FwdAddr,
  output logic [DATA_WIDTH-1:0] o_FwdData,
`endif
  output logic                  o_WrEnable,
  output logic [ADDR_WIDTH-1:0] o_WrAddr,
  output logic [DATA_WIDTH-1:0] o_WrData,
  output logic                  o_Busy
);

  localparam logic [ADDR_WIDTH-1:0] c_X0 = ADDR_WIDTH'(c_X0_ADDR);

  wb_state_t             r_State;
  wb_state_t             w_NextState;

  logic                  w_AluReady;
  logic                  w_MemReady;
  logic                  w_HoldLoad;
  logic                  w_WrReq;
  logic [ADDR_WIDTH-1:0] w_WrAddr;
  logic [DATA_WIDTH-1:0] w_WrData;

  logic [ADDR_WIDTH-1:0] w_HoldAddr;
  logic [DATA_WIDTH-1:0] w_HoldData;

  logic                  r_WrEnable;
  logic [ADDR_WIDTH-1:0] r_WrAddr;
  logic [DATA_WIDTH-1:0] r_WrData;

  // State register; reset always lands in IDLE, dropping any held entry.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Next-state, handshake readiness and selection of the write for next cycle.
  always_comb begin
    w_NextState = r_State;
    w_AluReady  = 1'b0;
    w_MemReady  = 1'b0;
    w_HoldLoad  = 1'b0;
    w_WrReq     = 1'b0;
    w_WrAddr    = c_X0;
    w_WrData    = INIT;

    case (r_State)
      IDLE: begin
        w_AluReady = ~i_Reset;
        w_MemReady = ~i_Reset;
        if (i_MemValid && w_MemReady) begin
          w_WrReq  = 1'b1;
          w_WrAddr = i_MemAddr;
          w_WrData = i_MemData;
          // Load has priority; a simultaneous ALU result is deferred.
          if (i_AluValid) begin
            w_HoldLoad  = 1'b1;
            w_NextState = HOLD;
          end
        end else if (i_AluValid && w_AluReady) begin
          w_WrReq  = 1'b1;
          w_WrAddr = i_AluAddr;
          w_WrData = i_AluData;
        end
      end
      HOLD: begin
        // Both sources are stalled here, so the held entry cannot be starved.
        w_WrReq     = 1'b1;
        w_WrAddr    = w_HoldAddr;
        w_WrData    = w_HoldData;
        w_NextState = IDLE;
      end
      default: begin
        w_NextState = IDLE;
      end
    endcase

    if (i_Reset) begin
      w_NextState = IDLE;
    end
  end

  writeback_hold #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Load  (w_HoldLoad),
    .i_Addr  (i_AluAddr),
    .i_Data  (i_AluData),
    .o_Addr  (w_HoldAddr),
    .o_Data  (w_HoldData)
  );

  // Registered write port; x0 requests keep address/data but drop the enable.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_WrEnable <= 1'b0;
      r_WrAddr   <= '0;
      r_WrData   <= INIT;
    end else if (w_WrReq) begin
      r_WrEnable <= (w_WrAddr != c_X0);
      r_WrAddr   <= w_WrAddr;
      r_WrData   <= w_WrData;
    end else begin
      r_WrEnable <= 1'b0;
      r_WrAddr   <= '0;
      r_WrData   <= INIT;
    end
  end

  assign o_AluReady = w_AluReady;
  assign o_MemReady = w_MemReady;
  assign o_WrEnable = r_WrEnable;
  assign o_WrAddr   = r_WrAddr;
  assign o_WrData   = r_WrData;
  assign o_Busy     = (r_State == HOLD);

`ifdef REGISTER_WRITEBACK_BYPASS_EN
  assign o_FwdValid = w_WrReq && (w_WrAddr != c_X0) && !i_Reset;
  assign o_FwdAddr  = w_WrAddr;
  assign o_FwdData  = w_WrData;
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_writeback.sv
`default_nettype none
// ============================================================================
// Module : tb_register_writeback
// Brief  : Randomised + directed bench for register_writeback with a
//          queue-based reference model and a decoupled output monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_register_writeback;

  localparam int             DW     = 32;
  localparam int             AW     = 5;
  localparam logic [DW-1:0]  c_INIT = 32'hDEAD_BEEF;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_rdy;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_rdy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
`ifdef REGISTER_WRITEBACK_BYPASS_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
`endif

  register_writeback #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .INIT       (c_INIT)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_AluValid (alu_valid),
    .i_AluAddr  (alu_addr),
    .i_AluData  (alu_data),
    .o_AluReady (alu_rdy),
    .i_MemValid (mem_valid),
    .i_MemAddr  (mem_addr),
    .i_MemData  (mem_data),
    .o_MemReady (mem_rdy),
`ifdef REGISTER_WRITEBACK_BYPASS_EN
    .o_FwdValid (fwd_valid),
    .o_FwdAddr  (fwd_addr),
    .o_FwdData  (fwd_data),
`endif
    .o_WrEnable (wr_en),
    .o_WrAddr   (wr_addr),
    .o_WrData   (wr_data),
    .o_Busy     (busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
  } out_t;

  req_t pend[$];   // accepted results not yet written, in write order
  out_t exp_q[$];  // expected write-port contents, one per cycle

  int checks = 0;
  int errors = 0;
  bit alu_fired = 0;
  bit mem_fired = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: results are written one per cycle in acceptance order,
  // load before ALU on the same cycle; sources are accepted only when
  // nothing is waiting and reset is low.
  always @(negedge clk) begin
    bit   exp_rdy;
    req_t r;
    out_t o;
    exp_rdy = !rst && (pend.size() == 0);
    checks++;
    if (alu_rdy !== exp_rdy || mem_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL ready t=%0t alu_rdy=%b mem_rdy=%b required=%b",
               $time, alu_rdy, mem_rdy, exp_rdy);
    end
    alu_fired = alu_valid && exp_rdy;
    mem_fired = mem_valid && exp_rdy;
    o = '{en: 1'b0, addr: '0, data: c_INIT, busy: 1'b0};
    if (rst) begin
      pend.delete();
    end else begin
      if (mem_fired) pend.push_back('{addr: mem_addr, data: mem_data});
      if (alu_fired) pend.push_back('{addr: alu_addr, data: alu_data});
      if (pend.size() > 0) begin
        r = pend.pop_front();
        o = '{en: (r.addr != 0), addr: r.addr, data: r.data,
              busy: (pend.size() > 0)};
      end
    end
    exp_q.push_back(o);
  end

  // Monitor: compare the registered write port against the model each cycle.
  always @(posedge clk) begin
    out_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (wr_en !== e.en || wr_addr !== e.addr || wr_data !== e.data ||
          busy !== e.busy) begin
        errors++;
        $display("FAIL wrport t=%0t got en=%b addr=%0d data=%h busy=%b required en=%b addr=%0d data=%h busy=%b",
                 $time, wr_en, wr_addr, wr_data, busy, e.en, e.addr, e.data, e.busy);
      end
    end
  end

  // Present requests, hold them until each is accepted; returns cycles taken.
  task automatic send(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      output int ncyc);
    bit a_pend;
    bit m_pend;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    a_pend = av;
    m_pend = mv;
    ncyc   = 0;
    while ((a_pend || m_pend) && ncyc < 20) begin
      @(posedge clk); #1;
      ncyc++;
      if (a_pend && alu_fired) begin a_pend = 0; alu_valid = 1'b0; end
      if (m_pend && mem_fired) begin m_pend = 0; mem_valid = 1'b0; end
    end
    if (a_pend || m_pend) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout alu_pending=%b mem_pending=%b required=0", a_pend, m_pend);
      alu_valid = 1'b0;
      mem_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_cycles(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s cycles=%0d required=%0d", name, got, req);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // Single ALU write
    send(1, 5'd5, 32'h1234, 0, '0, '0, n);
    expect_cycles("alu_single", n, 1);
    idle(2);

    // Collision: both accepted on the same edge, ALU written a cycle later
    send(1, 5'd7, 32'hBBBB, 1, 5'd3, 32'hAAAA, n);
    expect_cycles("collision", n, 1);
    idle(3);

    // x0 write completes the handshake without enabling the write
    send(1, 5'd0, 32'hFFFF, 0, '0, '0, n);
    expect_cycles("x0_handshake", n, 1);
    idle(2);

    // Reset while the hold entry is occupied
    send(1, 5'd9, 32'h0909_0909, 1, 5'd4, 32'h0404_0404, n);
    expect_cycles("collision_pre_reset", n, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);

    // Back-to-back ALU writes, no stalls expected
    for (int i = 1; i <= 8; i++) begin
      send(1, AW'(i), $urandom, 0, '0, '0, n);
      expect_cycles("b2b_alu", n, 1);
    end
    idle(2);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      bit            av, mv;
      logic [AW-1:0] aa, ma;
      av = ($urandom_range(0, 99) < 60);
      mv = ($urandom_range(0, 99) < 50);
      aa = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
      ma = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      if (av || mv) begin
        send(av, aa, $urandom, mv, ma, $urandom, n);
      end else begin
        idle(1);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
